// File: rtl/reg_bank_ctrl.sv
//==============================================================================
// Module   : reg_bank_ctrl
// Brief    : Round-robin access controller sequencing two requesters into the
//            register bank's select, read and write strobes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_bank_ctrl #(
    parameter int N_REGS = 8,
    parameter int AW     = 3,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_wdata,
    output logic              b_done,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic              busy,
    output logic [N_REGS-1:0] reg_sel,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic [DW-1:0]     reg_din,
    input  logic [DW-1:0]     reg_dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One extra bit so that N_REGS == 2**AW is representable.
    localparam logic [AW:0] c_n_regs = (AW+1)'(N_REGS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;      // 0 = port A has priority, 1 = port B
    logic            r_id;        // 0 = port A owns the transaction, 1 = port B
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            w_grant;
    logic            w_grant_b;
    logic            w_in_range;

    assign w_grant    = a_req | b_req;
    assign w_grant_b  = b_req & (~a_req | r_prio);
    assign w_in_range = ({1'b0, r_addr} < c_n_regs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        reg_rd      = 1'b0;
        reg_wr      = 1'b0;
        reg_din     = '0;
        a_done      = 1'b0;
        b_done      = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                reg_rd      = ~r_we;
                reg_wr      = r_we;
                reg_din     = r_wdata;
                w_state_nxt = r_we ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                a_done      = ~r_id;
                b_done      = r_id;
                err         = ~w_in_range;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Out-of-range addresses match no index, so the select stays all zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_sel
            assign reg_sel[gi] = (r_state == ST_ISSUE) && (r_addr == AW'(gi));
        end
    endgenerate

    assign busy  = (r_state != ST_IDLE);
    assign rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_grant) begin
                r_id    <= w_grant_b;
                r_prio  <= ~w_grant_b;
                r_we    <= w_grant_b ? b_we    : a_we;
                r_addr  <= w_grant_b ? b_addr  : a_addr;
                r_wdata <= w_grant_b ? b_wdata : a_wdata;
            end
            if (r_state == ST_CAPTURE) begin
                r_rdata <= w_in_range ? reg_dout : '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_ctrl.sv
//==============================================================================
// Module   : tb_reg_bank_ctrl
// Brief    : Directed self-checking bench; an 8-register and a 6-register
//            controller share stimulus, each driving its own bank model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_bank_ctrl;

    logic       clk;
    logic       rst;
    logic       preload;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;

    logic       a_done, b_done, err, busy, reg_rd, reg_wr;
    logic [7:0] rdata, reg_din, reg_dout, reg_sel;
    logic       a_done6, b_done6, err6, busy6, reg_rd6, reg_wr6;
    logic [7:0] rdata6, reg_din6, reg_dout6;
    logic [5:0] reg_sel6;

    logic [7:0] mem8 [8];
    logic [7:0] mem6 [6];

    int n_vec = 0;
    int n_err = 0;

    reg_bank_ctrl #(.N_REGS(8), .AW(3), .DW(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_done(b_done),
        .rdata(rdata), .err(err), .busy(busy),
        .reg_sel(reg_sel), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_din(reg_din),
        .reg_dout(reg_dout)
    );

    reg_bank_ctrl #(.N_REGS(6), .AW(3), .DW(8)) u_dut6 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_done(a_done6),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_done(b_done6),
        .rdata(rdata6), .err(err6), .busy(busy6),
        .reg_sel(reg_sel6), .reg_rd(reg_rd6), .reg_wr(reg_wr6), .reg_din(reg_din6),
        .reg_dout(reg_dout6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank models: write on the strobe edge, read data registered one cycle later.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem8[i] <= 8'hA0 + 8'(i);
        end else if (reg_wr) begin
            for (int i = 0; i < 8; i++) if (reg_sel[i]) mem8[i] <= reg_din;
        end
        if (reg_rd) begin
            reg_dout <= 8'h00;
            for (int i = 0; i < 8; i++) if (reg_sel[i]) reg_dout <= mem8[i];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 6; i++) mem6[i] <= 8'hA0 + 8'(i);
        end else if (reg_wr6) begin
            for (int i = 0; i < 6; i++) if (reg_sel6[i]) mem6[i] <= reg_din6;
        end
        if (reg_rd6) begin
            reg_dout6 <= 8'h00;
            for (int i = 0; i < 6; i++) if (reg_sel6[i]) reg_dout6 <= mem6[i];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete single-port transaction with cycle-exact checks.
    task automatic txn(input bit pb, input bit we, input logic [2:0] addr,
                       input logic [7:0] wd, input logic [7:0] e_rd8, input logic [7:0] e_rd6);
        logic [7:0] e_sel8;
        logic [5:0] e_sel6;
        bit         oor6;
        e_sel8 = 8'h01 << addr;
        oor6   = (addr >= 3'd6);
        e_sel6 = oor6 ? 6'h00 : (6'h01 << addr);
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        cyc();
        chk("issue_sel", reg_sel, e_sel8);
        chk("issue_sel6", reg_sel6, e_sel6);
        chk("issue_strb", {reg_rd, reg_wr, reg_din}, {~we, we, wd});
        cyc();
        if (!we) begin
            chk("capture_quiet", {reg_rd, reg_wr, reg_sel, busy}, {1'b0, 1'b0, 8'h00, 1'b1});
            cyc();
        end
        chk("done", {a_done, b_done, err}, {~pb, pb, 1'b0});
        chk("done6", {a_done6, b_done6, err6}, {~pb, pb, oor6});
        if (!we) begin
            chk("rdata", rdata, e_rd8);
            chk("rdata6", rdata6, e_rd6);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        cyc();
        chk("idle", {busy, a_done, b_done}, 3'b000);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; preload = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
        cyc();
        cyc();
        chk("reset_outs", {busy, a_done, b_done, err, reg_rd, reg_wr, reg_sel, reg_din, rdata}, '0);
        rst = 1'b0; preload = 1'b0;

        // Port A write then read of register 3
        txn(1'b0, 1'b1, 3'd3, 8'h5A, 8'h00, 8'h00);
        chk("mem8_3", mem8[3], 8'h5A);
        txn(1'b0, 1'b0, 3'd3, 8'h00, 8'h5A, 8'h5A);

        // Reset asserted while a read sits in CAPTURE
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2;
        cyc();
        chk("rst_issue_rd", reg_rd, 1'b1);
        cyc();
        chk("rst_capture", {busy, reg_rd}, 2'b10);
        rst = 1'b1; a_req = 1'b0;
        #1;
        chk("rst_async", {busy, a_done, b_done, err, reg_rd, reg_wr, reg_sel, reg_din, rdata}, '0);
        cyc();
        chk("rst_no_done1", {a_done, busy}, 2'b00);
        cyc();
        chk("rst_no_done2", {a_done, busy}, 2'b00);
        rst = 1'b0;
        cyc();
        chk("post_rst_idle", {busy, a_done, b_done}, 3'b000);

        // Simultaneous writes straight after reset: A first, then B
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd1; a_wdata = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd2; b_wdata = 8'h22;
        cyc();
        chk("arb1_issue", {reg_sel, reg_din}, {8'h02, 8'h11});
        cyc();
        chk("arb1_done", {a_done, b_done}, 2'b10);
        a_req = 1'b0;
        cyc();
        chk("arb1_idle", busy, 1'b0);
        cyc();
        chk("arb2_issue", {reg_sel, reg_din}, {8'h04, 8'h22});
        cyc();
        chk("arb2_done", {a_done, b_done}, 2'b01);
        b_req = 1'b0;
        cyc();
        chk("arb2_idle", busy, 1'b0);

        // Both held for four transactions: grants alternate A, B, A, B
        a_req = 1'b1; a_addr = 3'd4; a_wdata = 8'h44;
        b_req = 1'b1; b_addr = 3'd5; b_wdata = 8'h55;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("alt_issue", reg_sel, (k % 2 == 0) ? 8'h10 : 8'h20);
            cyc();
            chk("alt_done", {a_done, b_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 3) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            cyc();
            chk("alt_idle", busy, 1'b0);
        end

        // A holds req through its done; data change during ISSUE is ignored
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd6; a_wdata = 8'h66;
        cyc();
        chk("held1_issue", {reg_wr, reg_sel}, {1'b1, 8'h40});
        cyc();
        chk("held1_done", a_done, 1'b1);
        cyc();
        chk("held_gap_idle", {busy, a_done}, 2'b00);
        cyc();
        chk("held2_issue", {busy, reg_wr, reg_din}, {1'b1, 1'b1, 8'h66});
        a_wdata = 8'h99;
        cyc();
        chk("held2_done", a_done, 1'b1);
        a_req = 1'b0;
        cyc();
        chk("held_mem8_6", mem8[6], 8'h66);
        chk("held_end_idle", busy, 1'b0);

        // Range handling: the 6-register bank rejects addresses 6 and 7
        txn(1'b0, 1'b0, 3'd5, 8'h00, 8'h55, 8'h55);
        txn(1'b0, 1'b1, 3'd7, 8'h77, 8'h00, 8'h00);
        chk("mem6_untouched", {mem6[5], mem6[4], mem6[3], mem6[2], mem6[1], mem6[0]},
            48'h55_44_5A_22_11_A0);
        chk("mem8_7", mem8[7], 8'h77);
        txn(1'b1, 1'b0, 3'd7, 8'h00, 8'h77, 8'h00);
        txn(1'b0, 1'b0, 3'd6, 8'h00, 8'h66, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Access controller for the general-purpose register bank. Arbitrates between two requesters (port A: ALU writeback; port B: load/store bus unit) with round-robin fairness. Sequences each granted transaction into the bank's per-register select, read and write strobes, and captures read data back to the winner. It is the only driver of the bank's select and strobe lines.

## Interface
- N_REGS, 8, number of registers in the bank (1..2^AW)
- AW, 3, register address width
- DW, 8, data width

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held until a_done
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  AW  port A register index
- a_wdata  in  DW  port A write data
- a_done  out  1  port A one-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_done  same as port A, for port B
- rdata  out  DW  read data of the last completed read; valid while x_done is high
- err  out  1  high with x_done when the completed access had addr >= N_REGS
- busy  out  1  high in every state except IDLE
- reg_sel  out  N_REGS  one-hot register select to the bank
- reg_rd  out  1  bank read strobe
- reg_wr  out  1  bank write strobe
- reg_din  out  DW  write data to the bank
- reg_dout  in  DW  bank read data; registered inside the bank and valid the cycle after a read strobe

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any req is high at a clock edge, grant one requester and go to ISSUE.
  - Latch the winner's id, we, addr and wdata at that edge.
  - If no req is high, stay in IDLE.
- Arbitration:
  - A single request wins outright.
  - If both ports request, the port named by pointer `prio` wins.
  - `prio` then points to the loser. It updates only when a grant occurs.
  - `prio` resets to A.
- ISSUE, exactly one cycle:
  - reg_sel = onehot(latched addr); all zero if addr >= N_REGS.
  - reg_rd = !we; reg_wr = we; reg_din = latched wdata.
  - Next state is CAPTURE for a read, DONE for a write.
- CAPTURE (read only, exactly one cycle):
  - All strobes and reg_sel are low.
  - At the end of the cycle, rdata <= reg_dout, or 0 if addr is out of range.
  - Next state is DONE.
- DONE, exactly one cycle:
  - Winner's x_done = 1; err = 1 if addr >= N_REGS.
  - Next state is IDLE.
- Out-of-range access: no register is selected, a write is discarded, and a read returns 0x00. The access still completes with done and err.
- Outside ISSUE, reg_sel, reg_rd, reg_wr and reg_din are all 0. rdata holds its value until the next read capture.
- Requester inputs are ignored except at the IDLE grant edge. A change to addr or wdata after the grant has no effect.

## Timing
- Write latency: req sampled at edge 0 → ISSUE in cycle 1 → x_done high in cycle 2.
- Read latency: req sampled at edge 0 → ISSUE in cycle 1 → CAPTURE in cycle 2 → x_done and valid rdata in cycle 3.
- After DONE, the FSM spends one IDLE cycle before the next grant:
  - Back-to-back writes: 3 cycles each.
  - Back-to-back reads: 4 cycles each.
- A requester must drop req in its done cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- Reset values, immediate on rst assertion: state = IDLE, prio = A, all outputs 0, rdata = 0.
- Reset mid-transaction: the transaction is aborted, no done is issued, and a write in ISSUE may or may not have reached the bank. The first grant after reset release occurs at the first clock edge with rst low.
- Simultaneous A and B requests: exactly one is granted. The loser, if it keeps req high, is granted on the next IDLE grant edge.

## Test plan
- Reset: assert rst mid-read (in CAPTURE) → all outputs 0 at once, no a_done; after release, state is IDLE and busy = 0.
- Single write then read on port A:
  - Write addr 3, data 0x5A → reg_sel = 0x08, reg_wr = 1 for one cycle, a_done in cycle 2.
  - Read addr 3 → reg_rd = 1 in cycle 1, rdata = 0x5A with a_done in cycle 3.
- Contention: A and B both request writes at the same edge from reset (prio = A) → A is granted first and B next.
  - Repeat with both held continuously for 4 transactions → grants alternate A, B, A, B.
- Port B read of addr 7 while A stays idle → b_done only, a_done stays 0, rdata equals the bank model's value for register 7.
- With N_REGS = 6, read addr 6 → reg_sel = 0, rdata = 0x00, err = 1 with the done pulse.
  - A write to addr 7 leaves every register unchanged.
- Held request: A keeps a_req high through a_done → a second transaction starts after exactly one IDLE cycle.
  - Changing a_wdata during ISSUE does not alter the value written.
